// File: rtl/ddr2_read_capture.sv
// Read-data capture behind SAME_EDGE_PIPELINED IDDRs: a latency delay line times each burst.
// Optional macro DDR2_RDCAP_BURST_CNT_EN adds the saturating rd_burst_cnt output.
module ddr2_read_capture #(
    parameter int unsigned DQ_WIDTH   = 16,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned RD_LAT_MAX = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_cmd,
    input  logic [3:0]                    rd_lat,
    input  logic [DQ_WIDTH-1:0]           dq_rise,
    input  logic [DQ_WIDTH-1:0]           dq_fall,
    output logic [DQ_WIDTH*BURST_LEN-1:0] rd_data,
    output logic                          rd_valid,
    output logic                          rd_err
`ifdef DDR2_RDCAP_BURST_CNT_EN
    ,
    output logic [15:0]                   rd_burst_cnt
`endif
);

    localparam int unsigned Pairs = BURST_LEN / 2;
    localparam int unsigned CntW  = $clog2(Pairs);
    localparam int unsigned PairW = 2 * DQ_WIDTH;
    localparam logic [CntW-1:0] LastPair = CntW'(Pairs - 1);

    logic [RD_LAT_MAX-1:0]      dly_q;
    logic [CntW-1:0]            cnt_q;
    logic [(Pairs-1)*PairW-1:0] pair_buf_q;
    logic                       lat_ok;
    logic                       cmd_ok;
    logic                       start;
    logic                       overlap;
    logic                       done;

    always_comb begin
        lat_ok = (rd_lat != 4'd0) && (32'(rd_lat) <= RD_LAT_MAX);
        cmd_ok = rd_cmd && lat_ok;
        // dly_q[k] holds a command sampled k+1 edges ago, so tap rd_lat-1 lines up with pair 0.
        start  = 1'b0;
        for (int unsigned i = 0; i < RD_LAT_MAX; i++) begin
            if (32'(rd_lat) == i + 1) begin
                start = dly_q[i];
            end
        end
        overlap = start && (cnt_q != '0);
        done    = (cnt_q == LastPair);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q      <= '0;
            cnt_q      <= '0;
            pair_buf_q <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            dly_q    <= {dly_q[RD_LAT_MAX-2:0], cmd_ok};
            rd_valid <= 1'b0;
            if ((rd_cmd && !lat_ok) || overlap) begin
                rd_err <= 1'b1;
            end
            if (done) begin
                rd_data  <= {dq_fall, dq_rise, pair_buf_q};
                rd_valid <= 1'b1;
                cnt_q    <= '0;
            end else if (cnt_q != '0 || start) begin
                pair_buf_q[cnt_q*PairW +: PairW] <= {dq_fall, dq_rise};
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef DDR2_RDCAP_BURST_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_burst_cnt <= '0;
        end else if (done && rd_burst_cnt != 16'hFFFF) begin
            rd_burst_cnt <= rd_burst_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_read_capture.sv
// Bench for ddr2_read_capture: directed scenarios plus random traffic against an
// edge-indexed schedule model (start edge, busy window, completion edge).
module tb_ddr2_read_capture;

    localparam int DQ = 16;
`ifdef DDR2_RDCAP_BURST_CNT_EN
    localparam int BL = 8;
`else
    localparam int BL = 4;
`endif
    localparam int P = BL / 2;
    localparam int W = DQ * BL;
    localparam int N = 8192;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          rd_cmd  = 1'b0;
    logic [3:0]    rd_lat  = 4'd5;
    logic [DQ-1:0] dq_rise = '0;
    logic [DQ-1:0] dq_fall = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_err;
`ifdef DDR2_RDCAP_BURST_CNT_EN
    logic [15:0]   rd_burst_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int e      = 0;
    int vcount = 0;

    bit            start_at[N];
    bit            valid_at[N];
    logic [DQ-1:0] hr[N];
    logic [DQ-1:0] hf[N];
    int            busy_end;
    logic          m_err;
    logic          m_valid;
    logic [W-1:0]  m_data;
    int            m_cnt;

    ddr2_read_capture #(
        .DQ_WIDTH  (DQ),
        .BURST_LEN (BL),
        .RD_LAT_MAX(15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_cmd  (rd_cmd),
        .rd_lat  (rd_lat),
        .dq_rise (dq_rise),
        .dq_fall (dq_fall),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rd_err  (rd_err)
`ifdef DDR2_RDCAP_BURST_CNT_EN
        ,
        .rd_burst_cnt(rd_burst_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < N; i++) begin
            start_at[i] = 1'b0;
            valid_at[i] = 1'b0;
        end
        busy_end = 0;
        m_err    = 1'b0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_cnt    = 0;
    endtask

    // One edge of the reference: a burst owns edges [start, start+P); a start inside
    // an owned window is rejected.
    task automatic mstep(input logic c, input int lat);
        hr[e]   = dq_rise;
        hf[e]   = dq_fall;
        m_valid = 1'b0;
        if (c) begin
            if (lat == 0 || lat > 15) m_err = 1'b1;
            else start_at[e + lat] = 1'b1;
        end
        if (start_at[e]) begin
            if (e < busy_end) begin
                m_err = 1'b1;
            end else begin
                busy_end = e + P;
                valid_at[e + P - 1] = 1'b1;
            end
        end
        if (valid_at[e]) begin
            m_valid = 1'b1;
            for (int k = 0; k < P; k++) begin
                m_data[(2*k)*DQ +: DQ]   = hr[e - P + 1 + k];
                m_data[(2*k+1)*DQ +: DQ] = hf[e - P + 1 + k];
            end
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic check_all();
        chk("rd_valid", W'(rd_valid), W'(m_valid));
        chk("rd_err", W'(rd_err), W'(m_err));
        chk("rd_data", rd_data, m_data);
`ifdef DDR2_RDCAP_BURST_CNT_EN
        chk("rd_burst_cnt", W'(rd_burst_cnt), W'(m_cnt));
`endif
    endtask

    task automatic cyc(input logic c, input logic [DQ-1:0] r, input logic [DQ-1:0] f);
        rd_cmd  = c;
        dq_rise = r;
        dq_fall = f;
        @(posedge clk);
        e++;
        if (rst) mreset();
        else mstep(c, int'(rd_lat));
        #1;
        check_all();
        if (rd_valid) vcount++;
        rd_cmd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, DQ'($urandom), DQ'($urandom));
    endtask

    task automatic cmd_cyc();
        cyc(1'b1, DQ'($urandom), DQ'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst    = 1'b0;
        vcount = 0;
    endtask

    logic [W-1:0] nom;

    initial begin
        mreset();
        do_reset();

        // Nominal read: command at edge 10, pairs at edges 15.., rd_lat = 5.
        rd_lat = 4'd5;
        idle(9);
        cmd_cyc();
        idle(4);
        nom = '0;
        for (int k = 0; k < P; k++) begin
            nom[(2*k)*DQ +: DQ]   = DQ'(32'h1111 * (2*k + 1));
            nom[(2*k+1)*DQ +: DQ] = DQ'(32'h1111 * (2*k + 2));
            cyc(1'b0, DQ'(32'h1111 * (2*k + 1)), DQ'(32'h1111 * (2*k + 2)));
        end
        chk("nominal_valid", W'(rd_valid), W'(1));
        chk("nominal_data", rd_data, nom);
        idle(5);
        chk("nominal_hold", rd_data, nom);

        // Gapless back-to-back reads.
        do_reset();
        idle(9);
        cmd_cyc();
        idle(P - 1);
        cmd_cyc();
        idle(15);
        chk("b2b_count", W'(vcount), W'(2));
        chk("b2b_err", W'(rd_err), W'(0));

        // Overlapping start one edge later is dropped.
        do_reset();
        idle(9);
        cmd_cyc();
        cmd_cyc();
        idle(15);
        chk("overlap_count", W'(vcount), W'(1));
        chk("overlap_err", W'(rd_err), W'(1));

        // Asynchronous reset after pair 0 of a burst.
        vcount = 0;
        idle(9);
        cmd_cyc();
        idle(5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_data", rd_data, '0);
        chk("async_valid", W'(rd_valid), W'(0));
        chk("async_err", W'(rd_err), W'(0));
        mreset();
        check_all();
        idle(2);
        rst = 1'b0;
        vcount = 0;
        idle(20);
        chk("after_rst_count", W'(vcount), W'(0));

        // Illegal latency: dropped, sticky error.
        do_reset();
        rd_lat = 4'd0;
        idle(3);
        cmd_cyc();
        idle(20);
        chk("illegal_count", W'(vcount), W'(0));
        chk("illegal_err", W'(rd_err), W'(1));
        rd_lat = 4'd5;
        idle(10);
        chk("illegal_err_sticky", W'(rd_err), W'(1));

        // Three reads at rd_lat = 3.
        do_reset();
        rd_lat = 4'd3;
        idle(2);
        for (int i = 0; i < 3; i++) begin
            cmd_cyc();
            idle(P + 1);
        end
        idle(10);
        chk("three_count", W'(vcount), W'(3));
`ifdef DDR2_RDCAP_BURST_CNT_EN
        chk("three_burst_cnt", W'(rd_burst_cnt), W'(3));
`endif

        // Random traffic, one static latency per phase.
        for (int ph = 0; ph < 10; ph++) begin
            do_reset();
            rd_lat = (ph == 4) ? 4'd0 : 4'($urandom_range(1, 15));
            for (int i = 0; i < 300; i++) begin
                cyc(($urandom_range(0, 2 * P - 1) == 0), DQ'($urandom), DQ'($urandom));
            end
            idle(20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr2_read_capture.md
DDR2_READ_CAPTURE -- requirements
Module: ddr2_read_capture

Interface
REQ-001 Parameter DQ_WIDTH, default 16, is the DQ bits per IDDR bank (rise and fall lane width).
REQ-002 Parameter BURST_LEN, default 4, is the DDR beats per read burst; legal values are 4 and 8 only.
REQ-003 Parameter RD_LAT_MAX, default 15, is the latency shift-register depth in clk cycles.
REQ-004 Port clk, input, 1 bit, is the controller clock, the same clock that drives the IDDR C pins.
REQ-005 Port rst, input, 1 bit, is an asynchronous, active-high reset.
REQ-006 Port rd_cmd, input, 1 bit, is a one-cycle pulse for each READ issued to the DRAM.
REQ-007 Port rd_lat, input, 4 bits, is the cycles from rd_cmd to the first beat pair at dq_rise/dq_fall; it SHALL be held static while reads are in flight.
REQ-008 Port dq_rise, input, DQ_WIDTH bits, is the rising-edge beat (IDDR Q1, SAME_EDGE_PIPELINED).
REQ-009 Port dq_fall, input, DQ_WIDTH bits, is the falling-edge beat (IDDR Q2, SAME_EDGE_PIPELINED).
REQ-010 Port rd_data, output, DQ_WIDTH*BURST_LEN bits, is the assembled burst.
REQ-011 Port rd_valid, output, 1 bit, is a one-cycle pulse marking rd_data valid.
REQ-012 Port rd_err, output, 1 bit, is a sticky error flag.

Function
REQ-013 rd_cmd sampled at edge T0 SHALL enter a delay line; the burst start tap SHALL fire so that the beat pair present at edge T0+rd_lat is captured as pair 0.
REQ-014 Capture SHALL take BURST_LEN/2 consecutive edges (pairs 0..BURST_LEN/2-1), tracked by a beat-pair counter that wraps to 0 after the last pair.
REQ-015 Beat ordering SHALL be: slot 2k = dq_rise of pair k; slot 2k+1 = dq_fall of pair k; slot n occupies rd_data[n*DQ_WIDTH +: DQ_WIDTH].
REQ-016 At the edge capturing the last pair, rd_data SHALL load {last pair, previously buffered pairs} and rd_valid SHALL assert, both registered; rd_valid is therefore high in the cycle after edge T0+rd_lat+BURST_LEN/2-1.
REQ-017 rd_valid SHALL be high for exactly one cycle per burst; rd_data SHALL hold its value until the next rd_valid.
REQ-018 rd_cmd pulses spaced exactly BURST_LEN/2 cycles apart SHALL produce gapless captures with no lost pair.
REQ-019 If a start tap fires while the counter is nonzero (overlap), the new burst SHALL be dropped, the current burst SHALL complete normally, and rd_err SHALL set.
REQ-020 rd_cmd with rd_lat=0 or rd_lat>RD_LAT_MAX SHALL be dropped, SHALL set rd_err, and SHALL produce no rd_valid.
REQ-021 rd_err SHALL remain set until rst; it SHALL NOT clear on any other event.
REQ-022 rd_cmd may be high on the same edge a capture completes or starts; the delay line SHALL accept it independently of capture state.

Reset
REQ-023 On rst=1, the delay line, counter, buffer, rd_data, rd_valid, and rd_err SHALL clear to 0 immediately, without waiting for clk.
REQ-024 A burst in flight or partially captured when rst asserts SHALL be discarded and SHALL produce no rd_valid after rst deasserts.
REQ-025 rd_cmd SHALL be ignored while rst=1.

Configuration
REQ-026 With macro DDR2_RDCAP_BURST_CNT_EN defined, the block SHALL add output rd_burst_cnt, 16 bits, reset to 0, incrementing on each rd_valid and saturating at 16'hFFFF.
REQ-027 Without DDR2_RDCAP_BURST_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Nominal read: DQ_WIDTH=16, BURST_LEN=4, rd_lat=5, rd_cmd at edge 10, rise/fall 16'h1111/16'h2222 at edge 15 and 16'h3333/16'h4444 at edge 16 -> rd_valid high one cycle after edge 16, rd_data=64'h4444_3333_2222_1111.
REQ-029 Back-to-back: rd_cmd at edges 10 and 12, rd_lat=5 -> two rd_valid pulses, after edges 16 and 18, with correct data each and rd_err=0.
REQ-030 Overlap: rd_cmd at edges 10 and 11 -> one rd_valid (first burst) and rd_err=1 from edge 16 onward.
REQ-031 Illegal latency: rd_lat=0, rd_cmd pulsed -> no rd_valid and rd_err=1; rd_err remains 1 until rst.
REQ-032 Reset mid-burst: rst asserted between edges 15 and 16 of the REQ-028 scenario -> all outputs are 0 asynchronously and no rd_valid follows.
REQ-033 BURST_LEN=8 with macro defined: three reads at rd_lat=3 -> 128-bit words assembled correctly and rd_burst_cnt=3.
